regfile_write_arbiter: RTL and testbench

Shares the single write port of the 32-entry register file (Read1/Read2/WriteReg/WriteData/RegWrite, W-bit data) between two writeback sources: requester 0 (ALU writeback) and requester 1 (load/memory writeback).
- Each requester gets a small FIFO with a valid/ready handshake.
- A round-robin scheduler drains one write per cycle into a registered output stage.
- The output stage drives the register file's WriteReg/WriteData/RegWrite inputs directly.

---
 rtl/regfile_write_arbiter.sv | 157 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-source round-robin arbiter for the register file write port (option: REGFILE_ARB_REG0_DISCARD_EN)

module regfile_write_arbiter_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [4:0]               push_reg,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [4:0]               head_reg,
    output logic [W-1:0]             head_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [4:0]    reg_mem  [DEPTH];
    logic [W-1:0]  data_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push && !flush) begin
            reg_mem[wr_ptr]  <= push_reg;
            data_mem[wr_ptr] <= push_data;
        end
    end

    assign head_reg  = reg_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];
endmodule

module regfile_write_arbiter #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         req0_valid,
    input  logic [4:0]   req0_reg,
    input  logic [W-1:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [4:0]   req1_reg,
    input  logic [W-1:0] req1_data,
    output logic         req1_ready,
    output logic         RegWrite,
    output logic [4:0]   WriteReg,
    output logic [W-1:0] WriteData,
    output logic         pending
);
    localparam int            CW   = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [CW-1:0] count0, count1;
    logic [4:0]    head0_reg, head1_reg, sel_reg;
    logic [W-1:0]  head0_data, head1_data, sel_data;
    logic          push0, push1, pop0, pop1;
    logic          nonempty0, nonempty1;
    logic          grant0, grant1, write_en;
    logic          last_grant;

    // Ready looks only at registered counts so it never depends on this cycle's pop.
    assign req0_ready = (count0 < FULL) & !flush;
    assign req1_ready = (count1 < FULL) & !flush;
    assign push0      = req0_valid & req0_ready;
    assign push1      = req1_valid & req1_ready;

    assign nonempty0 = (count0 != '0);
    assign nonempty1 = (count1 != '0);
    assign grant0    = nonempty0 & (!nonempty1 | last_grant);
    assign grant1    = nonempty1 & (!nonempty0 | !last_grant);
    assign pop0      = grant0 & !flush;
    assign pop1      = grant1 & !flush;

    regfile_write_arbiter_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo0 (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .push      (push0),
        .push_reg  (req0_reg),
        .push_data (req0_data),
        .pop       (pop0),
        .head_reg  (head0_reg),
        .head_data (head0_data),
        .count     (count0)
    );

    regfile_write_arbiter_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo1 (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .push      (push1),
        .push_reg  (req1_reg),
        .push_data (req1_data),
        .pop       (pop1),
        .head_reg  (head1_reg),
        .head_data (head1_data),
        .count     (count1)
    );

    always_comb begin
        sel_reg  = grant1 ? head1_reg  : head0_reg;
        sel_data = grant1 ? head1_data : head0_data;
`ifdef REGFILE_ARB_REG0_DISCARD_EN
        // A reg-0 entry still spends its turn, it just never strobes the write enable.
        write_en = (grant0 | grant1) & (sel_reg != 5'd0);
`else
        write_en = grant0 | grant1;
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            RegWrite   <= 1'b0;
            WriteReg   <= '0;
            WriteData  <= '0;
            last_grant <= 1'b1;
        end else if (flush) begin
            RegWrite <= 1'b0;
        end else begin
            RegWrite <= write_en;
            if (grant0 | grant1) begin
                WriteReg   <= sel_reg;
                WriteData  <= sel_data;
                last_grant <= grant1;
            end
        end
    end

    assign pending = nonempty0 | nonempty1 | RegWrite;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter against a queue model

module tb_regfile_write_arbiter;
    localparam int W     = 32;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         flush = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [4:0]   req0_reg = '0, req1_reg = '0;
    logic [W-1:0] req0_data = '0, req1_data = '0;
    logic         req0_ready, req1_ready;
    logic         RegWrite;
    logic [4:0]   WriteReg;
    logic [W-1:0] WriteData;
    logic         pending;

    regfile_write_arbiter #(.W(W), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (flush),
        .req0_valid (req0_valid),
        .req0_reg   (req0_reg),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_reg   (req1_reg),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .RegWrite   (RegWrite),
        .WriteReg   (WriteReg),
        .WriteData  (WriteData),
        .pending    (pending)
    );

    always #5 clock = ~clock;

    int   checks = 0;
    int   errors = 0;
    ent_t q0[$], q1[$];
    ent_t src0[$], src1[$];
    ent_t wlog[$];
    int   last_g = 1;
    bit   exp_rw = 0;
    ent_t exp_f = '0;
    bit   known = 1;
    bit   hold0 = 0, hold1 = 0;
    bit   drv0 = 0, drv1 = 0;
    int   rate0 = 100, rate1 = 100;
    logic obs_rdy0, obs_rdy1;
    int   run_len, max_run;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete(); q1.delete(); src0.delete(); src1.delete();
        last_g = 1; exp_rw = 0; exp_f = '0; known = 1;
        hold0 = 0; hold1 = 0; drv0 = 0; drv1 = 0;
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        flush = 1'b0;
        #1;
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic step(input bit fl);
        ent_t e;
        int   g;
        bit   acc0, acc1;
        if (!hold0) drv0 = (src0.size() > 0) && ($urandom_range(99) < rate0);
        if (!hold1) drv1 = (src1.size() > 0) && ($urandom_range(99) < rate1);
        req0_valid = drv0;
        req1_valid = drv1;
        if (drv0) {req0_reg, req0_data} = src0[0];
        if (drv1) {req1_reg, req1_data} = src1[0];
        flush = fl;
        #2;
        obs_rdy0 = req0_ready;
        obs_rdy1 = req1_ready;
        chk("req0_ready", req0_ready, (q0.size() < DEPTH) && !fl);
        chk("req1_ready", req1_ready, (q1.size() < DEPTH) && !fl);
        acc0 = drv0 && (q0.size() < DEPTH) && !fl;
        acc1 = drv1 && (q1.size() < DEPTH) && !fl;
        @(posedge clock);
        if (fl) begin
            q0.delete(); q1.delete();
            exp_rw = 0;
        end else begin
            g = -1;
            if (q0.size() > 0 && q1.size() > 0) g = (last_g == 1) ? 0 : 1;
            else if (q0.size() > 0) g = 0;
            else if (q1.size() > 0) g = 1;
            if (g >= 0) begin
                e = (g == 0) ? q0.pop_front() : q1.pop_front();
                last_g = g;
`ifdef REGFILE_ARB_REG0_DISCARD_EN
                exp_rw = (e.r != 5'd0);
`else
                exp_rw = 1;
`endif
                if (exp_rw) exp_f = e;
                known = exp_rw;
            end else begin
                exp_rw = 0;
            end
            if (acc0) q0.push_back(src0.pop_front());
            if (acc1) q1.push_back(src1.pop_front());
        end
        hold0 = drv0 && !acc0;
        hold1 = drv1 && !acc1;
        #1;
        chk("RegWrite", RegWrite, exp_rw);
        if (known) begin
            chk("WriteReg", WriteReg, exp_f.r);
            chk("WriteData", WriteData, exp_f.d);
        end
        chk("pending", pending, (q0.size() != 0) || (q1.size() != 0) || exp_rw);
        if (RegWrite === 1'b1) begin
            wlog.push_back({WriteReg, WriteData});
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((src0.size() || src1.size() || q0.size() || q1.size() || exp_rw) && n < budget) begin
            step(0);
            n++;
        end
        chk("drain_done", (src0.size() + src1.size() + q0.size() + q1.size()), 0);
    endtask

    initial begin
        do_reset();
        chk("rst_RegWrite", RegWrite, 0);
        chk("rst_WriteReg", WriteReg, 0);
        chk("rst_WriteData", WriteData, 0);
        chk("rst_pending", pending, 0);

        // single write
        src0.push_back({5'd5, 32'hDEADBEEF});
        step(0);
        step(0);
        chk("single_we", RegWrite, 1);
        chk("single_reg", WriteReg, 5);
        chk("single_data", WriteData, 32'hDEADBEEF);
        step(0);
        chk("single_pending", pending, 0);

        // contention, round-robin
        do_reset();
        wlog.delete(); run_len = 0; max_run = 0;
        for (int i = 1; i <= 3; i++) begin
            src0.push_back({5'(i), 32'(i * 100)});
            src1.push_back({5'(i + 10), 32'(i * 1000)});
        end
        drain(20);
        chk("rr_count", wlog.size(), 6);
        if (wlog.size() == 6) begin
            chk("rr_0", wlog[0].r, 1);
            chk("rr_1", wlog[1].r, 11);
            chk("rr_2", wlog[2].r, 2);
            chk("rr_3", wlog[3].r, 12);
            chk("rr_4", wlog[4].r, 3);
            chk("rr_5", wlog[5].r, 13);
        end
        chk("rr_consecutive", max_run, 6);

        // backpressure: req1 alone on a busy req0, then both streaming
        wlog.delete();
        src0.push_back({5'd20, 32'h20});
        src0.push_back({5'd21, 32'h21});
        step(0);
        step(0);
        for (int i = 0; i < 6; i++) src1.push_back({5'(i + 1), 32'hB000 + 32'(i)});
        drain(40);
        chk("bp1_count", wlog.size(), 8);
        wlog.delete();
        for (int i = 0; i < 8; i++) begin
            src0.push_back({5'(i + 1), 32'hA100 + 32'(i)});
            src1.push_back({5'(i + 16), 32'hB100 + 32'(i)});
        end
        drain(60);
        chk("bp2_count", wlog.size(), 16);

        // flush
        for (int i = 0; i < 3; i++) begin
            src0.push_back({5'(i + 4), 32'hC0 + 32'(i)});
            src1.push_back({5'(i + 24), 32'hD0 + 32'(i)});
        end
        step(0);
        step(0);
        step(0);
        src0.delete(); src1.delete(); hold1 = 0;
        src0.push_back({5'd30, 32'hF00D});
        hold0 = 1; drv0 = 1;
        step(1);
        chk("flush_ready0", obs_rdy0, 0);
        chk("flush_we", RegWrite, 0);
        src0.delete(); hold0 = 0;
        wlog.delete();
        step(0);
        step(0);
        chk("flush_nowrites", wlog.size(), 0);
        chk("flush_pending", pending, 0);

        // async reset mid-burst
        for (int i = 0; i < 3; i++) begin
            src0.push_back({5'(i + 7), 32'hE0 + 32'(i)});
            src1.push_back({5'(i + 17), 32'hE8 + 32'(i)});
        end
        step(0);
        step(0);
        step(0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_RegWrite", RegWrite, 0);
        chk("arst_WriteReg", WriteReg, 0);
        chk("arst_WriteData", WriteData, 0);
        chk("arst_pending", pending, 0);
        model_reset();
        #1;
        reset_n = 1'b1;
        step(0);
        wlog.delete();
        src0.push_back({5'd7, 32'h77});
        src1.push_back({5'd17, 32'h1717});
        drain(10);
        chk("arst_tie_first", (wlog.size() > 0) ? wlog[0].r : 5'h1f, 7);

        // register 0
        do_reset();
        wlog.delete();
        src0.push_back({5'd0, 32'h1234});
        step(0);
        src0.push_back({5'd9, 32'h99});
        src1.push_back({5'd19, 32'h1919});
        drain(10);
`ifdef REGFILE_ARB_REG0_DISCARD_EN
        chk("reg0_count", wlog.size(), 2);
        chk("reg0_next_tie", (wlog.size() > 0) ? wlog[0].r : 5'h1f, 19);
`else
        chk("reg0_count", wlog.size(), 3);
        chk("reg0_reg", (wlog.size() > 0) ? wlog[0].r : 5'h1f, 0);
        chk("reg0_data", (wlog.size() > 0) ? wlog[0].d : 32'hFFFF_FFFF, 32'h1234);
`endif

        // randomized traffic with occasional flush
        rate0 = 60;
        rate1 = 60;
        for (int i = 0; i < 400; i++) begin
            if (src0.size() < 2) src0.push_back({5'($urandom_range(31)), 32'($urandom)});
            if (src1.size() < 2) src1.push_back({5'($urandom_range(31)), 32'($urandom)});
            step($urandom_range(49) == 0);
        end
        rate0 = 100;
        rate1 = 100;
        drain(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
